// File: rtl/model_vector_integer_accumulator_if.sv
// Handshake/data bundle between the product stream source and the integer accumulator.
interface model_vector_integer_accumulator_if #(
    parameter int DATA_SIZE = 64
);
    logic                 START;
    logic                 READY;
    logic                 DATA_IN_ENABLE;
    logic [DATA_SIZE-1:0] SIZE_IN;
    logic [DATA_SIZE-1:0] DATA_IN;
    logic [DATA_SIZE-1:0] DATA_OUT;
    logic [DATA_SIZE-1:0] OVERFLOW_OUT;

    modport master (
        output START,
        output DATA_IN_ENABLE,
        output SIZE_IN,
        output DATA_IN,
        input  READY,
        input  DATA_OUT,
        input  OVERFLOW_OUT
    );

    modport slave (
        input  START,
        input  DATA_IN_ENABLE,
        input  SIZE_IN,
        input  DATA_IN,
        output READY,
        output DATA_OUT,
        output OVERFLOW_OUT
    );
endinterface

// File: rtl/model_vector_integer_accumulator.sv
// Reduces SIZE_IN unsigned elements to a scalar sum with carries kept in OVERFLOW_OUT.
// Define MODEL_VECTOR_ACCUMULATOR_SATURATE_EN for a saturating sum with a sticky overflow flag.
module model_vector_integer_accumulator #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input logic CLK,
    input logic RST,
    model_vector_integer_accumulator_if.slave bus
);
    localparam logic [1:0] STARTER_STATE = 2'd0;
    localparam logic [1:0] INPUT_STATE   = 2'd1;
    localparam logic [1:0] ENDER_STATE   = 2'd2;

    localparam int CW = (DATA_SIZE > CONTROL_SIZE) ? DATA_SIZE : CONTROL_SIZE;

    logic [1:0]              state;
    logic [DATA_SIZE-1:0]    size_int;
    logic [DATA_SIZE-1:0]    acc_lo;
    logic [CONTROL_SIZE-1:0] index;
    logic [CW-1:0]           index_ext;
    logic [CW-1:0]           size_last;
    logic                    last_element;

    // Counter and size may differ in width; compare in the wider of the two.
    assign index_ext    = CW'(index);
    assign size_last    = CW'(size_int) - CW'(1);
    assign last_element = (index_ext == size_last);

`ifdef MODEL_VECTOR_ACCUMULATOR_SATURATE_EN
    logic                 sat_flag;
    logic [DATA_SIZE:0]   lo_sum;

    assign lo_sum = {1'b0, acc_lo} + {1'b0, bus.DATA_IN};
`else
    logic [DATA_SIZE-1:0]   acc_hi;
    logic [2*DATA_SIZE-1:0] wide_sum;

    assign wide_sum = {acc_hi, acc_lo} + {{DATA_SIZE{1'b0}}, bus.DATA_IN};
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state            <= STARTER_STATE;
            size_int         <= '0;
            acc_lo           <= '0;
            index            <= '0;
            bus.READY        <= 1'b0;
            bus.DATA_OUT     <= '0;
            bus.OVERFLOW_OUT <= '0;
`ifdef MODEL_VECTOR_ACCUMULATOR_SATURATE_EN
            sat_flag         <= 1'b0;
`else
            acc_hi           <= '0;
`endif
        end else begin
            bus.READY <= 1'b0;
            case (state)
                STARTER_STATE: begin
                    if (bus.START) begin
                        size_int <= bus.SIZE_IN;
                        acc_lo   <= '0;
                        index    <= '0;
`ifdef MODEL_VECTOR_ACCUMULATOR_SATURATE_EN
                        sat_flag <= 1'b0;
`else
                        acc_hi   <= '0;
`endif
                        state    <= (bus.SIZE_IN == '0) ? ENDER_STATE : INPUT_STATE;
                    end
                end
                INPUT_STATE: begin
                    if (bus.DATA_IN_ENABLE) begin
`ifdef MODEL_VECTOR_ACCUMULATOR_SATURATE_EN
                        // Once clamped the sum stays at all-ones for the rest of the run.
                        if (lo_sum[DATA_SIZE] || sat_flag) begin
                            acc_lo   <= '1;
                            sat_flag <= 1'b1;
                        end else begin
                            acc_lo   <= lo_sum[DATA_SIZE-1:0];
                        end
`else
                        {acc_hi, acc_lo} <= wide_sum;
`endif
                        if (last_element) begin
                            state <= ENDER_STATE;
                        end else begin
                            index <= index + CONTROL_SIZE'(1);
                        end
                    end
                end
                ENDER_STATE: begin
                    bus.DATA_OUT     <= acc_lo;
`ifdef MODEL_VECTOR_ACCUMULATOR_SATURATE_EN
                    bus.OVERFLOW_OUT <= {{(DATA_SIZE-1){1'b0}}, sat_flag};
`else
                    bus.OVERFLOW_OUT <= acc_hi;
`endif
                    bus.READY        <= 1'b1;
                    state            <= STARTER_STATE;
                end
                default: begin
                    state <= STARTER_STATE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_model_vector_integer_accumulator.sv
// Scoreboard bench for model_vector_integer_accumulator at DATA_SIZE=8, CONTROL_SIZE=8.
module tb_model_vector_integer_accumulator;
    logic CLK = 1'b0;
    logic RST = 1'b0;

    always #5 CLK = ~CLK;

    model_vector_integer_accumulator_if #(.DATA_SIZE(8)) bus ();

    model_vector_integer_accumulator #(
        .DATA_SIZE   (8),
        .CONTROL_SIZE(8)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

`ifdef MODEL_VECTOR_ACCUMULATOR_SATURATE_EN
    localparam logic [7:0] CARRY_D = 8'd255, CARRY_O = 8'd1;
    localparam logic [7:0] B2B_D   = 8'd255, B2B_O   = 8'd1;
`else
    localparam logic [7:0] CARRY_D = 8'd38,  CARRY_O = 8'd2;
    localparam logic [7:0] B2B_D   = 8'd44,  B2B_O   = 8'd1;
`endif

    typedef struct {
        logic [7:0]  data;
        logic [7:0]  ovf;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  last_data = '0;
    logic [7:0]  last_ovf = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    // Monitor: cyc equals the number of the rising edge just passed.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (bus.READY === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_ready: got READY=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("ready_cycle", 64'(cyc), 64'(e.cyc));
                    check("data_out", 64'(bus.DATA_OUT), 64'(e.data));
                    check("overflow_out", 64'(bus.OVERFLOW_OUT), 64'(e.ovf));
                    last_data = e.data;
                    last_ovf  = e.ovf;
                end
            end else if (RST) begin
                check("hold_data", 64'(bus.DATA_OUT), 64'(last_data));
                check("hold_ovf", 64'(bus.OVERFLOW_OUT), 64'(last_ovf));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // SIZE_IN is scrambled after the accepting edge; the running reduction must ignore it.
    task automatic do_start(input logic [7:0] sz, input logic [7:0] ed, input logic [7:0] eo);
        bus.START   = 1'b1;
        bus.SIZE_IN = sz;
        if (sz == 8'd0) sb.push_back('{data: ed, ovf: eo, cyc: cyc + 2});
        @(negedge CLK);
        bus.START   = 1'b0;
        bus.SIZE_IN = 8'hA5;
    endtask

    task automatic send(input logic [7:0] v, input bit last, input logic [7:0] ed, input logic [7:0] eo);
        bus.DATA_IN        = v;
        bus.DATA_IN_ENABLE = 1'b1;
        if (last) sb.push_back('{data: ed, ovf: eo, cyc: cyc + 2});
        @(negedge CLK);
        bus.DATA_IN_ENABLE = 1'b0;
        bus.DATA_IN        = 8'hEE;
    endtask

    initial begin
        bus.START          = 1'b0;
        bus.DATA_IN_ENABLE = 1'b0;
        bus.SIZE_IN        = '0;
        bus.DATA_IN        = '0;
        #1;
        check("reset_ready", 64'(bus.READY), 64'd0);
        check("reset_data", 64'(bus.DATA_OUT), 64'd0);
        check("reset_ovf", 64'(bus.OVERFLOW_OUT), 64'd0);
        idle(2);
        RST = 1'b1;
        idle(1);

        // Basic: 1+2+3+4
        do_start(8'd4, 8'd0, 8'd0);
        send(8'd1, 0, 0, 0);
        send(8'd2, 0, 0, 0);
        send(8'd3, 0, 0, 0);
        send(8'd4, 1, 8'd10, 8'd0);
        idle(3);

        // Carry: 200+100+250 = 550
        do_start(8'd3, 8'd0, 8'd0);
        send(8'd200, 0, 0, 0);
        send(8'd100, 0, 0, 0);
        send(8'd250, 1, CARRY_D, CARRY_O);
        idle(3);

        // Gaps: dropped enable before START, idle cycles and an ignored START mid-run
        send(8'd50, 0, 0, 0);
        idle(1);
        do_start(8'd2, 8'd0, 8'd0);
        send(8'd7, 0, 0, 0);
        idle(2);
        bus.START   = 1'b1;
        bus.SIZE_IN = 8'd1;
        @(negedge CLK);
        bus.START   = 1'b0;
        idle(2);
        send(8'd9, 1, 8'd16, 8'd0);
        idle(3);

        // Zero size
        do_start(8'd0, 8'd0, 8'd0);
        idle(3);

        // Previous result nonzero so the reset clear is observable
        do_start(8'd1, 8'd0, 8'd0);
        send(8'd77, 1, 8'd77, 8'd0);
        idle(3);

        // Reset mid-run: no READY, outputs cleared at once
        do_start(8'd4, 8'd0, 8'd0);
        send(8'd3, 0, 0, 0);
        send(8'd4, 0, 0, 0);
        RST       = 1'b0;
        last_data = '0;
        last_ovf  = '0;
        #1;
        check("abort_ready", 64'(bus.READY), 64'd0);
        check("abort_data", 64'(bus.DATA_OUT), 64'd0);
        check("abort_ovf", 64'(bus.OVERFLOW_OUT), 64'd0);
        idle(2);
        RST = 1'b1;
        idle(1);
        do_start(8'd2, 8'd0, 8'd0);
        send(8'd5, 0, 0, 0);
        send(8'd5, 1, 8'd10, 8'd0);
        idle(2);

        // Back-to-back: second START lands in the READY cycle
        do_start(8'd2, 8'd0, 8'd0);
        send(8'd200, 0, 0, 0);
        send(8'd100, 1, B2B_D, B2B_O);
        idle(1);
        do_start(8'd2, 8'd0, 8'd0);
        send(8'd1, 0, 0, 0);
        send(8'd1, 1, 8'd2, 8'd0);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge CLK);
        idle(3);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
